// File: rtl/lsu.sv
// lsu: RV32 load/store unit between the MEM stage and dmem.
// Checks alignment, drives one dmem request, returns the extended result or a cause.
module lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [3:0]  cause_o,
    output logic [31:0] badaddr_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [3:0]    cause_q;
    logic [CW-1:0] cnt_q;

    logic        accept;
    logic        illegal;
    logic        misal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] ext;
    logic        timeout;

    assign ready_o     = (state_q == IDLE) & ~rst_i;
    assign mem_ready_o = ~rst_i;
    assign accept      = valid_i & ready_o;

    assign mem_valid_o = (state_q == REQ);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = wdata_q;

    assign valid_o   = (state_q == RESP);
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign cause_o   = cause_q;
    assign badaddr_o = err_q ? addr_q : 32'h0;

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Unsigned widths are loads only; a store with them is undefined.
    always_comb begin
        illegal = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)
                | (we_i & funct3_i[2]);
        misal   = 1'b0;
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        unique case (1'b1)
            (funct3_i[1:0] == 2'b00): begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            (funct3_i[1:0] == 2'b01): begin
                misal   = addr_i[0];
                be_d    = 4'b0011 << addr_i[1:0];
                wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                misal = (addr_i[1:0] != 2'b00);
            end
        endcase
    end

    always_comb begin
        shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
        ext     = shifted;
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (illegal | misal) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid_i | timeout) state_d = RESP;
            end
            RESP: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cause_q <= 4'h0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= we_i;
                        f3_q    <= funct3_i;
                        addr_q  <= addr_i;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        rdata_q <= 32'h0;
                        err_q   <= illegal | misal;
                        if (illegal)    cause_q <= 4'd2;
                        else if (misal) cause_q <= we_i ? 4'd6 : 4'd4;
                        else            cause_q <= 4'd0;
                    end
                end
                REQ: begin
                    if (mem_ready_i) cnt_q <= '0;
                end
                WAIT: begin
                    // A response arriving on the last wait cycle beats the timeout.
                    if (mem_valid_i) begin
                        rdata_q <= we_q ? 32'h0 : ext;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        cause_q <= we_q ? 4'd7 : 4'd5;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed table-driven bench for lsu with a small dmem model.
// Timeout, coincident-response and reset corners are hand-sequenced.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [3:0]  cause_o;
    logic [31:0] badaddr_o;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_valid_i(mem_valid_i),
        .mem_ready_o(mem_ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .cause_o    (cause_o),
        .badaddr_o  (badaddr_o)
    );

    // dmem model: one-cycle read latency, byte-enable writes, optional silence.
    logic [31:0] mem [0:15];
    logic        pend = 1'b0;
    logic [31:0] pdata = 32'h0;
    logic        resp_en;
    logic        force_mv;

    always @(posedge clk) begin
        if (mem_valid_o && mem_ready_i) begin
            pend  <= resp_en;
            pdata <= mem[mem_addr_o[5:2]];
            if (mem_we_o) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_be_o[i])
                        mem[mem_addr_o[5:2]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
                end
            end
        end else begin
            pend <= 1'b0;
        end
    end

    assign mem_valid_i = pend | force_mv;
    assign mem_rdata_i = pdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [3:0]  cause;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] mwd;
        int          lat;
        int          rq_stall;
        int          wb_stall;
        bit          no_resp;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic err, input logic [3:0] cause,
                       input logic [31:0] rd, input logic [3:0] be,
                       input logic [31:0] mwd, input int lat,
                       input int rqs, input int wbs, input bit nr);
        vec_t t;
        t.we = we; t.f3 = f3; t.addr = addr; t.wd = wd;
        t.err = err; t.cause = cause; t.rd = rd; t.be = be;
        t.mwd = mwd; t.lat = lat; t.rq_stall = rqs;
        t.wb_stall = wbs; t.no_resp = nr;
        tv.push_back(t);
    endtask

    task automatic run(input vec_t v, input int n);
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        bit          saw, unstable;
        int          lat, st;
        string       p;
        p = $sformatf("v%0d_", n);
        a0 = 0; w0 = 0; b0 = 0; we0 = 0;
        resp_en = !v.no_resp;
        chk({p, "ready_idle"}, {31'h0, ready_o}, 32'h1);
        valid_i = 1'b1; we_i = v.we; funct3_i = v.f3;
        addr_i = v.addr; wdata_i = v.wd;
        step;
        valid_i = 1'b0;
        lat = 1; saw = 0; unstable = 0; st = v.rq_stall;
        while (!valid_o && lat < 40) begin
            if (mem_valid_o) begin
                if (!saw) begin
                    a0 = mem_addr_o; b0 = mem_be_o;
                    w0 = mem_wdata_o; we0 = mem_we_o; saw = 1;
                end else if (mem_addr_o !== a0 || mem_be_o !== b0 ||
                             mem_wdata_o !== w0 || mem_we_o !== we0) begin
                    unstable = 1;
                end
                mem_ready_i = (st == 0);
                if (st > 0) st--;
            end
            step;
            lat++;
        end
        mem_ready_i = 1'b1;
        chk({p, "lat"}, lat, v.lat);
        chk({p, "err"}, {31'h0, err_o}, {31'h0, v.err});
        chk({p, "cause"}, {28'h0, cause_o}, {28'h0, v.cause});
        chk({p, "rdata"}, rdata_o, v.rd);
        chk({p, "badaddr"}, badaddr_o, v.err ? v.addr : 32'h0);
        chk({p, "mem_used"}, {31'h0, saw}, (v.lat > 1) ? 32'h1 : 32'h0);
        if (saw) begin
            chk({p, "be"}, {28'h0, b0}, {28'h0, v.be});
            chk({p, "mwdata"}, w0, v.mwd);
            chk({p, "maddr"}, a0, {v.addr[31:2], 2'b00});
            chk({p, "mwe"}, {31'h0, we0}, {31'h0, v.we});
            chk({p, "req_stable"}, {31'h0, unstable}, 32'h0);
        end
        for (int i = 0; i < v.wb_stall; i++) begin
            step;
            chk({p, "hold_valid"}, {31'h0, valid_o}, 32'h1);
            chk({p, "hold_ready"}, {31'h0, ready_o}, 32'h0);
            chk({p, "hold_rdata"}, rdata_o, v.rd);
        end
        ready_i = 1'b1;
        step;
        ready_i = 1'b0;
        chk({p, "done_valid"}, {31'h0, valid_o}, 32'h0);
        chk({p, "done_ready"}, {31'h0, ready_o}, 32'h1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "valid_o"}, {31'h0, valid_o}, 32'h0);
        chk({p, "err_o"}, {31'h0, err_o}, 32'h0);
        chk({p, "mem_valid_o"}, {31'h0, mem_valid_o}, 32'h0);
        chk({p, "mem_we_o"}, {31'h0, mem_we_o}, 32'h0);
        chk({p, "mem_be_o"}, {28'h0, mem_be_o}, 32'h0);
        chk({p, "rdata_o"}, rdata_o, 32'h0);
        chk({p, "cause_o"}, {28'h0, cause_o}, 32'h0);
        chk({p, "badaddr_o"}, badaddr_o, 32'h0);
        chk({p, "mem_addr_o"}, mem_addr_o, 32'h0);
        chk({p, "mem_wdata_o"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_i = 1'b1; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0; mem_ready_i = 1'b1;
        ready_i = 1'b0; resp_en = 1'b1; force_mv = 1'b0;
        step; step;
        chk("rst_ready_o", {31'h0, ready_o}, 32'h0);
        chk("rst_mem_ready_o", {31'h0, mem_ready_o}, 32'h0);
        chk_zero("rst_");
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready_o", {31'h0, ready_o}, 32'h1);
        chk("post_rst_mem_ready_o", {31'h0, mem_ready_o}, 32'h1);

        add(1, 3'b000, 32'h1002, 32'h000000A5, 0, 0, 32'h0, 4'b0100, 32'hA5A5A5A5, 3, 0, 0, 0);
        add(0, 3'b000, 32'h1002, 32'h0, 0, 0, 32'hFFFFFFA5, 4'b0100, 32'h0, 3, 0, 0, 0);
        add(0, 3'b100, 32'h1002, 32'h0, 0, 0, 32'h000000A5, 4'b0100, 32'h0, 3, 0, 0, 0);
        add(1, 3'b001, 32'h1006, 32'h12348001, 0, 0, 32'h0, 4'b1100, 32'h80018001, 3, 0, 0, 0);
        add(0, 3'b001, 32'h1006, 32'h0, 0, 0, 32'hFFFF8001, 4'b1100, 32'h0, 3, 0, 0, 0);
        add(0, 3'b101, 32'h1006, 32'h0, 0, 0, 32'h00008001, 4'b1100, 32'h0, 3, 0, 0, 0);
        add(1, 3'b010, 32'h1008, 32'hDEADBEEF, 0, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 6, 3, 0, 0);
        add(0, 3'b010, 32'h1008, 32'h0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 3, 0, 2, 0);
        add(0, 3'b000, 32'h1009, 32'h0, 0, 0, 32'hFFFFFFBE, 4'b0010, 32'h0, 3, 0, 0, 0);
        add(0, 3'b100, 32'h100B, 32'h0, 0, 0, 32'h000000DE, 4'b1000, 32'h0, 3, 0, 0, 0);
        add(0, 3'b001, 32'h1008, 32'h0, 0, 0, 32'hFFFFBEEF, 4'b0011, 32'h0, 3, 0, 0, 0);
        add(0, 3'b101, 32'h100A, 32'h0, 0, 0, 32'h0000DEAD, 4'b1100, 32'h0, 3, 0, 0, 0);
        add(1, 3'b000, 32'h1003, 32'h1234567F, 0, 0, 32'h0, 4'b1000, 32'h7F7F7F7F, 3, 0, 0, 0);
        add(0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h0000007F, 4'b1000, 32'h0, 3, 0, 0, 0);
        add(0, 3'b010, 32'h1001, 32'h0, 1, 4, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(1, 3'b001, 32'h1003, 32'h5555, 1, 6, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(1, 3'b101, 32'h1000, 32'h1, 1, 2, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(1, 3'b100, 32'h1000, 32'h1, 1, 2, 32'h0, 4'h0, 32'h0, 1, 0, 1, 0);
        add(0, 3'b011, 32'h1000, 32'h0, 1, 2, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(0, 3'b110, 32'h1002, 32'h0, 1, 2, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(1, 3'b010, 32'h1002, 32'h0, 1, 6, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(0, 3'b001, 32'h1001, 32'h0, 1, 4, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        add(0, 3'b000, 32'h1008, 32'h0, 1, 5, 32'h0, 4'b0001, 32'h0, 6, 0, 0, 1);
        add(1, 3'b010, 32'h1030, 32'h11111111, 1, 7, 32'h0, 4'b1111, 32'h11111111, 6, 0, 0, 1);

        foreach (tv[i]) run(tv[i], i);

        // Response on the final wait cycle must win over the timeout.
        resp_en = 1'b0;
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h1008; wdata_i = 32'h0;
        step;
        valid_i = 1'b0;
        step; step; step; step;
        force_mv = 1'b1;
        step;
        force_mv = 1'b0;
        chk("coin_valid", {31'h0, valid_o}, 32'h1);
        chk("coin_err", {31'h0, err_o}, 32'h0);
        chk("coin_rdata", rdata_o, 32'hDEADBEEF);
        ready_i = 1'b1;
        step;
        ready_i = 1'b0;

        // Reset while waiting, then a late response must be ignored.
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h1009; wdata_i = 32'h0;
        step;
        valid_i = 1'b0;
        step; step;
        rst_i = 1'b1;
        step;
        chk("wrst_ready_o", {31'h0, ready_o}, 32'h0);
        chk_zero("wrst_");
        rst_i = 1'b0;
        force_mv = 1'b1;
        step;
        force_mv = 1'b0;
        chk_zero("late_");
        chk("late_ready_o", {31'h0, ready_o}, 32'h1);
        step;
        chk("late2_valid_o", {31'h0, valid_o}, 32'h0);

        resp_en = 1'b1;
        begin
            vec_t t;
            t.we = 0; t.f3 = 3'b010; t.addr = 32'h1008; t.wd = 0;
            t.err = 0; t.cause = 0; t.rd = 32'hDEADBEEF;
            t.be = 4'b1111; t.mwd = 0; t.lat = 3;
            t.rq_stall = 0; t.wb_stall = 0; t.no_resp = 0;
            run(t, 99);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the MEM pipeline stage and `dmem`. It accepts one RV32 load/store per handshake and detects misaligned or undefined accesses. For legal accesses it builds the word-aligned address, byte enables and lane-replicated write data, then issues one `dmem` request and captures `dmem`'s one-cycle-latency read data. It returns a sign- or zero-extended result, or an exception cause, to writeback over a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles in WAIT before an access fault is reported.
- `clk_i  in  1`: clock; all state updates on the rising edge.
- `rst_i  in  1`: synchronous, active-high reset.
- `valid_i  in  1`: request from the MEM stage.
- `ready_o  out  1`: the LSU can accept a request; equals (state==IDLE) & !rst_i.
- `we_i  in  1`: 1 = store, 0 = load.
- `funct3_i  in  3`: RV32 width code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr_i  in  32`: byte address.
- `wdata_i  in  32`: store data (rs2).
- `mem_valid_o  out  1`: request to `dmem`.
- `mem_ready_i  in  1`: `dmem` accepts.
- `mem_we_o  out  1`: write enable to `dmem`.
- `mem_be_o  out  4`: byte enables to `dmem`.
- `mem_addr_o  out  32`: word-aligned address, {addr[31:2],2'b00}.
- `mem_wdata_o  out  32`: lane-replicated store data.
- `mem_rdata_i  in  32`: `dmem` read data; valid only in the cycle `mem_valid_i`=1.
- `mem_valid_i  in  1`: `dmem` response.
- `mem_ready_o  out  1`: ready to `dmem`; constant 1 except 0 while rst_i.
- `valid_o  out  1`: response to writeback.
- `ready_i  in  1`: writeback accepts.
- `rdata_o  out  32`: extended load result; 0 for stores and errors.
- `err_o  out  1`: the response is an exception.
- `cause_o  out  4`: mcause code; meaningful only when err_o=1.
- `badaddr_o  out  32`: the faulting addr_i, for mtval.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **Accept.** A request is accepted when valid_i && ready_o in IDLE. On accept, register we, funct3, addr[1:0], the full address, be and wdata.
- **Illegal access.** Any of the following goes IDLE→RESP with err_o=1 and cause 2; no memory access is made:
  - funct3 ∈ {011,110,111};
  - a store with funct3 100 or 101.
- **Misaligned access.** H/HU with addr[0]=1, or W with addr[1:0]≠0, goes IDLE→RESP with err_o=1 and no memory access. cause is 4 for a load, 6 for a store.
- **Legal access.** IDLE→REQ.
- **REQ.** mem_valid_o=1 with stable mem_* signals. Go to WAIT on mem_ready_i=1; otherwise hold.
- **WAIT.** mem_valid_o=0.
  - On mem_valid_i=1: capture the extended result and go to RESP.
  - If the wait counter reaches TIMEOUT_CYCLES first: go to RESP with err_o=1, cause 5 (load) or 7 (store).
- **RESP.** valid_o=1 with rdata_o, err_o, cause_o and badaddr_o held stable until ready_i=1, then IDLE.
- **Store lanes:**
  - B: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - H: be = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - W: be = 1111, wdata = rs2.
- **Load extract:** shifted = mem_rdata_i >> (8·addr[1:0]).
  - B: sign-extend shifted[7:0]; BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0]; HU: zero-extend shifted[15:0].
  - W: shifted.
- Stores complete on mem_valid_i with rdata_o=0, err_o=0.
- mem_valid_i is ignored outside WAIT.

## Timing
- **Reset values:**
  - state IDLE;
  - valid_o, err_o, mem_valid_o, mem_we_o all 0;
  - mem_be_o, rdata_o, cause_o, badaddr_o, mem_addr_o, mem_wdata_o all 0;
  - wait counter 0.
- Reset in any state returns to IDLE at the next edge and drops a pending response.
- **Legal access, mem_ready_i=1:**
  - accept at cycle 0;
  - REQ in cycle 1;
  - mem_valid_i sampled in cycle 2;
  - valid_o=1 in cycle 3.
  - This is 3 cycles of latency; back-to-back throughput is one access per 4 cycles.
- Error responses: accept at cycle 0, valid_o=1 in cycle 1.
- Each cycle REQ holds with mem_ready_i=0 adds one cycle of latency. REQ has no timeout.
- **Wait counter:** cleared on entry to WAIT, incremented each WAIT cycle without mem_valid_i. A timeout is taken when the counter equals TIMEOUT_CYCLES−1 and mem_valid_i=0.
- If mem_valid_i and the timeout condition coincide, mem_valid_i wins.
- valid_o is a registered state output; ready_o is combinational from state only. Neither depends combinationally on valid_i or ready_i.

## Test plan
- **SB then LB.** SB addr 0x…02, wdata 0x000000A5: mem_be_o=0100, mem_wdata_o=0xA5A5A5A5, mem_addr_o=0x…00. Then LB at the same address: rdata_o=0xFFFFFFA5 in cycle 3. LBU: 0x000000A5.
- **SH then LH/LHU.** SH addr 0x…02, rs2 0x12348001: be=1100. Then LH returns 0xFFFF8001; LHU returns 0x00008001.
- **Misaligned.** LW addr 0x…01: no mem_valid_o; valid_o in cycle 1 with err_o=1, cause 4, badaddr_o=0x…01. SH addr 0x…03: cause 6.
- **Illegal store.** Store with funct3 101: err_o=1, cause 2, no mem_valid_o.
- **Backpressure.**
  - mem_ready_i held 0 for 3 cycles in REQ: mem_* signals stay stable and valid_o arrives in cycle 6.
  - ready_i held 0 for 2 cycles in RESP: outputs stay stable and ready_o stays 0.
- **Timeout and reset.**
  - mem_valid_i never asserted with TIMEOUT_CYCLES=4: err_o=1 with cause 5 (load) or 7 (store), 4 cycles after entering WAIT.
  - rst_i pulsed while in WAIT: IDLE on the next edge and all outputs return to 0. A late mem_valid_i is ignored.
